// File: rtl/seq_detector_if.sv
// seq_detector_if: symbol stream, control and result signals of the
// serial pattern detector, bundled so source and detector share one port.
interface seq_detector_if #(
  parameter int W     = 2,
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  localparam int FW = $clog2(N + 1);

  logic             clear;
  logic             valid;
  logic [W-1:0]     sym;
  logic [N*W-1:0]   pattern;
  logic             overlap;
  logic             hit;
  logic             found;
  logic [CNT_W-1:0] match_cnt;
  logic [FW-1:0]    fill;

  // Symbol source: drives the stream and control, observes results
  modport master (
    output clear, valid, sym, pattern, overlap,
    input  hit, found, match_cnt, fill
  );

  // Detector: consumes the stream and control, drives results
  modport slave (
    input  clear, valid, sym, pattern, overlap,
    output hit, found, match_cnt, fill
  );
endinterface

// File: rtl/seq_detector.sv
// seq_detector: parametrised serial pattern detector.
// Shifts accepted W-bit symbols into an N-symbol window and compares the
// window against a runtime pattern. Each match pulses hit for one cycle and
// bumps a saturating match counter.
// Optional feature macro: SEQ_DET_STICKY_EN -- when defined, found latches
// on the first match (LOCK state) until reset or clear; otherwise found
// simply mirrors hit.
module seq_detector #(
  parameter int W     = 2,
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  seq_detector_if.slave bus
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0]    FULL    = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef SEQ_DET_STICKY_EN
  typedef enum logic [1:0] {IDLE, SCAN, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

  state_t           state;
  logic [N*W-1:0]   win_q;
  logic [FW-1:0]    fill_q;
  logic             hit_q;
  logic             found_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N*W-1:0]   win_nxt;
  logic [FW-1:0]    fill_nxt;
  logic             match;

  // Newest symbol enters at the top of the window; oldest falls out the bottom
  if (N == 1) begin : g_win_single
    assign win_nxt = bus.sym;
  end else begin : g_win_shift
    assign win_nxt = {bus.sym, win_q[N*W-1:W]};
  end

  // Occupancy and match test for the symbol being offered this cycle
  always_comb begin
    fill_nxt = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match    = (fill_nxt == FULL) && (win_nxt == bus.pattern);
  end

  // Control FSM with window, counter and registered result flags
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state   <= IDLE;
      win_q   <= '0;
      fill_q  <= '0;
      hit_q   <= 1'b0;
      found_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.valid) begin
      win_q  <= win_nxt;
      fill_q <= (match && !bus.overlap) ? '0 : fill_nxt;
      hit_q  <= match;
      if (match && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
`ifdef SEQ_DET_STICKY_EN
      if (match) begin
        state   <= LOCK;
        found_q <= 1'b1;
      end else if (state == IDLE) begin
        state <= SCAN;
      end
`else
      found_q <= match;
      if (state == IDLE)
        state <= SCAN;
`endif
    end else begin
      hit_q <= 1'b0;
`ifndef SEQ_DET_STICKY_EN
      found_q <= 1'b0;
`endif
    end
  end

  assign bus.hit       = hit_q;
  assign bus.found     = found_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: scoreboard bench for seq_detector. The driver applies one
// cycle of stimulus per negedge, steps a queue-based reference model and
// pushes the expected post-edge outputs; the monitor pops and compares after
// every rising edge.
module tb_seq_detector;
  localparam int W     = 2;
  localparam int N     = 3;
  localparam int CNT_W = 3;
  localparam int FW    = $clog2(N + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic             hit;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic [FW-1:0]    fill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_detector_if #(.W(W), .N(N), .CNT_W(CNT_W)) bus ();

  seq_detector #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t         sb[$];
  logic [W-1:0] hist[$];
  int           m_cnt    = 0;
  bit           m_hit    = 0;
  bit           m_sticky = 0;
  int           vectors  = 0;
  int           miscompares = 0;

  // Reference: symbols remembered since the last reset/clear/consuming match
  task automatic modelStep(input bit r, input bit c, input bit v,
                           input logic [W-1:0] s,
                           input logic [N*W-1:0] pat, input bit ov);
    bit m;
    if (!r || c) begin
      hist.delete();
      m_cnt = 0;
      m_hit = 0;
      m_sticky = 0;
    end else if (v) begin
      hist.push_back(s);
      if (hist.size() > N) void'(hist.pop_front());
      m = (hist.size() == N);
      for (int k = 0; k < N; k++)
        if (m && hist[k] != pat[k*W +: W]) m = 0;
      m_hit = m;
      if (m) begin
        if (m_cnt < CMAX) m_cnt++;
        m_sticky = 1;
        if (!ov) hist.delete();
      end
    end else begin
      m_hit = 0;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic applyStimulus(input bit r, input bit c, input bit v,
                               input logic [W-1:0] s,
                               input logic [N*W-1:0] pat, input bit ov);
    exp_t e;
    @(negedge clk);
    rst_n       = r;
    bus.clear   = c;
    bus.valid   = v;
    bus.sym     = s;
    bus.pattern = pat;
    bus.overlap = ov;
    modelStep(r, c, v, s, pat, ov);
    e.hit  = m_hit;
`ifdef SEQ_DET_STICKY_EN
    e.found = m_sticky;
`else
    e.found = m_hit;
`endif
    e.cnt  = CNT_W'(m_cnt);
    e.fill = FW'(hist.size());
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (bus.hit !== e.hit) begin
      miscompares++;
      $display("[TB] FAIL hit @%0t: got %b want %b", $time, bus.hit, e.hit);
    end
    if (bus.found !== e.found) begin
      miscompares++;
      $display("[TB] FAIL found @%0t: got %b want %b", $time, bus.found, e.found);
    end
    if (bus.match_cnt !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL match_cnt @%0t: got %0d want %0d", $time, bus.match_cnt, e.cnt);
    end
    if (bus.fill !== e.fill) begin
      miscompares++;
      $display("[TB] FAIL fill @%0t: got %0d want %0d", $time, bus.fill, e.fill);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  task automatic feed(input logic [N*W-1:0] pat, input bit ov,
                      input logic [W-1:0] s);
    applyStimulus(1, 0, 1, s, pat, ov);
  endtask

  task automatic idle(input logic [N*W-1:0] pat, input bit ov);
    applyStimulus(1, 0, 0, 2'b00, pat, ov);
  endtask

  localparam logic [5:0] P123 = 6'b111001;
  localparam logic [5:0] P111 = 6'b010101;

  initial begin
    int budget;
    bus.clear = 0; bus.valid = 0; bus.sym = 0; bus.pattern = P123; bus.overlap = 1;

    // reset state
    applyStimulus(0, 0, 0, 2'b00, P123, 1);
    applyStimulus(0, 0, 1, 2'b01, P123, 1);

    // basic match 01,10,11
    feed(P123, 1, 2'b01); feed(P123, 1, 2'b10); feed(P123, 1, 2'b11);
    idle(P123, 1); idle(P123, 1);
    applyStimulus(1, 1, 0, 2'b00, P123, 1);

    // broken stream: only the final three symbols match
    feed(P123, 1, 2'b01); feed(P123, 1, 2'b01); feed(P123, 1, 2'b10);
    feed(P123, 1, 2'b00); feed(P123, 1, 2'b11); feed(P123, 1, 2'b01);
    feed(P123, 1, 2'b10); feed(P123, 1, 2'b11); idle(P123, 1);
    applyStimulus(1, 1, 0, 2'b00, P123, 1);

    // 1,1,1,1,1 with overlap, then without
    for (int i = 0; i < 5; i++) feed(P111, 1, 2'b01);
    applyStimulus(1, 1, 0, 2'b00, P111, 1);
    for (int i = 0; i < 5; i++) feed(P111, 0, 2'b01);
    applyStimulus(1, 1, 0, 2'b00, P111, 0);

    // valid gaps freeze state
    feed(P123, 1, 2'b01); idle(P123, 1); idle(P123, 1); idle(P123, 1);
    feed(P123, 1, 2'b10); idle(P123, 1); feed(P123, 1, 2'b11); idle(P123, 1);

    // saturation: 9 overlapping matches on all-ones, then clear
    applyStimulus(1, 1, 0, 2'b00, P111, 1);
    for (int i = 0; i < 11; i++) feed(P111, 1, 2'b01);
    applyStimulus(1, 1, 1, 2'b01, P111, 1);
    idle(P111, 1);

    // reset on the completing edge discards the symbol, then a clean match
    feed(P123, 1, 2'b01); feed(P123, 1, 2'b10);
    applyStimulus(0, 0, 1, 2'b11, P123, 1);
    feed(P123, 1, 2'b01); feed(P123, 1, 2'b10); feed(P123, 1, 2'b11);
    // clear on the completing edge likewise
    feed(P123, 1, 2'b01); feed(P123, 1, 2'b10);
    applyStimulus(1, 1, 1, 2'b11, P123, 1);

    // randomized phases with small alphabet so matches are frequent
    for (int ph = 0; ph < 20; ph++) begin
      logic [N*W-1:0] pat;
      bit ov;
      pat = N*W'($urandom);
      ov  = $urandom_range(0, 1);
      for (int i = 0; i < 150; i++) begin
        bit r, c, v;
        logic [W-1:0] s;
        r = ($urandom_range(0, 199) != 0);
        c = ($urandom_range(0, 79) == 0);
        v = ($urandom_range(0, 3) != 0);
        s = W'($urandom);
        if ($urandom_range(0, 4) == 0) s = pat[W-1:0];
        if ($urandom_range(0, 60) == 0) pat = N*W'($urandom);
        if ($urandom_range(0, 40) == 0) ov = ~ov;
        applyStimulus(r, c, v, s, pat, ov);
      end
    end

    idle(bus.pattern, bus.overlap);
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial pattern detector. It accepts one W-bit symbol per valid cycle and compares the last N accepted symbols against a runtime-programmable pattern. On each match it raises a one-cycle hit pulse and increments a saturating match counter, with a compile-time option for a sticky found flag. It is the general-purpose successor to the fixed 3-symbol, 2-bit detector used in the Pre exercises, and sits on any symbol stream that needs sequence recognition.

## Interface
- W, default 2: symbol width in bits (≥1).
- N, default 3: pattern length in symbols (≥1).
- CNT_W, default 8: match counter width (≥1).
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous, active-low reset.
- clear  input  1  synchronous soft clear. Same effect as reset; no effect on parameters.
- valid  input  1  qualifies sym; a symbol is accepted on a rising edge when valid=1.
- sym  input  W  incoming symbol.
- pattern  input  N*W  target sequence. Symbol k (k=0 is first in time) is at bits [k*W +: W].
- overlap  input  1  1: overlapping matches allowed; 0: a match consumes its symbols.
- hit  output  1  one-cycle pulse, high in the cycle after the completing symbol is accepted.
- found  output  1  match indicator (see Configuration).
- match_cnt  output  CNT_W  number of matches since reset/clear, saturating.
- fill  output  $clog2(N+1)  number of valid symbols in the window, 0..N.

## Operation
- Window register win (N*W bits). win[W-1:0] holds the oldest symbol; the top W bits hold the newest. Accept: win ← {sym, win[N*W-1:W]}.
- fill_nxt = min(fill+1, N) on accept.
- Match condition, evaluated on the accept edge: fill_nxt==N and shifted window == pattern. pattern is sampled at that same edge.
- Control FSM states:
  - IDLE: after reset or clear, with fill=0. Moves to SCAN on the first accept.
  - SCAN: accumulating or comparing symbols.
  - LOCK: only when STICKY_EN is defined. Entered on the first match. Matching, hit and counting continue in LOCK; only found is affected by the state.
- On match:
  - hit ← 1 for one cycle.
  - match_cnt ← match_cnt+1, saturating at 2^CNT_W−1 (never wraps).
  - If overlap=0, fill ← 0 and the window contents are ignored until N new symbols arrive. If overlap=1, fill stays N.
- No accept (valid=0): all state holds and hit ← 0.
- Priority order: rst_n=0 > clear=1 > valid.
- Reset and clear values: win=0, fill=0, hit=0, found=0, match_cnt=0, state=IDLE.
- Changing pattern mid-stream does not flush the window. The next compare uses the new pattern against the existing window.
- Changing overlap takes effect at the next match.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: the completing symbol is accepted at edge t; hit, match_cnt and found update at edge t and are visible during cycle t→t+1.
- Back-to-back accepts are supported every cycle (throughput 1 symbol/cycle).
- Overlapping matches on consecutive accepts produce consecutive hit cycles.
- Reset or clear asserted in the same cycle as a completing symbol: the symbol is discarded and no hit or count occurs.
- N=1: every accepted symbol equal to pattern produces a hit. fill is 0 or 1.

## Configuration
- SEQ_DET_STICKY_EN defined: found is set on the first match and held (LOCK state) until rst_n=0 or clear=1.
- SEQ_DET_STICKY_EN undefined: there is no LOCK state and found is identical to hit.

## Test plan
- W=2, N=3, pattern=6'b111001 (01,10,11), overlap=1. Feed 01,10,11 on consecutive cycles → hit=1 for exactly one cycle after the third accept; match_cnt=1; found=1 and held with STICKY_EN, found drops with hit without it.
- Same pattern, stream 01,01,10,00,11,01,10,11 → exactly one hit, after the final symbol; match_cnt=1. The intermediate 00 breaks the match.
- pattern=6'b010101 (1,1,1). Stream 1,1,1,1,1: overlap=1 → 3 hits on accepts 3, 4 and 5; overlap=0 → 1 hit on accept 3 only, and fill returns to 0 then 2.
- valid gaps: 01,(valid=0 ×3),10,(valid=0),11 → a single hit after 11; state is frozen during the gaps.
- CNT_W=2, overlap=1, 6 matches → match_cnt=3, saturated. Then clear=1 for one cycle → match_cnt=0, fill=0, found=0, hit=0.
- rst_n=0 asserted on the same edge as the completing 11 → no hit, match_cnt=0, fill=0; the next 01,10,11 → hit.
